// File: rtl/cic_integrator_decimator.sv
// CIC decimator front half: STAGES cascaded wrapping integrators followed by a
// rate-R downsampler. It emits one output strobe every R accepted samples.
module cic_integrator_decimator #(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned RATE_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ena,
    input  logic [IN_WIDTH-1:0]   x_in,
    input  logic [RATE_WIDTH-1:0] rate,
    output logic [WIDTH-1:0]      y_out,
    output logic                  y_valid,
    output logic                  rate_err
);

    logic [STAGES-1:0][WIDTH-1:0] acc_q, acc_d;
    logic [RATE_WIDTH-1:0]        cnt_q, cnt_d;
    logic [RATE_WIDTH-1:0]        rate_q;
    logic [RATE_WIDTH-1:0]        eff_c;
    logic [WIDTH-1:0]             y_out_q;
    logic                         y_valid_q;
    logic                         rate_err_q;
    logic [WIDTH-1:0]             x_ext_c;
    logic                         frame_start_c;
    logic                         frame_end_c;

    assign x_ext_c = WIDTH'($signed(x_in));

    // Every stage sums pre-edge values, so each integrator adds one register of delay.
    always_comb begin
        acc_d    = acc_q;
        acc_d[0] = acc_q[0] + x_ext_c;
        for (int unsigned k = 1; k < STAGES; k++) begin
            acc_d[k] = acc_q[k] + acc_q[k-1];
        end
    end

    // The rate is sampled only at frame start. A rate of 0 runs as R = 1.
    always_comb begin
        frame_start_c = (cnt_q == '0);
        eff_c         = rate_q;
        if (frame_start_c) begin
            eff_c = (rate == '0) ? RATE_WIDTH'(1) : rate;
        end
        frame_end_c = (cnt_q == eff_c - RATE_WIDTH'(1));
        cnt_d       = frame_end_c ? '0 : cnt_q + RATE_WIDTH'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            rate_q     <= RATE_WIDTH'(1);
            y_out_q    <= '0;
            y_valid_q  <= 1'b0;
            rate_err_q <= 1'b0;
        end else begin
            y_valid_q  <= 1'b0;
            rate_err_q <= 1'b0;
            if (ena) begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
                if (frame_start_c) begin
                    rate_q     <= eff_c;
                    rate_err_q <= (rate == '0);
                end
                if (frame_end_c) begin
                    y_out_q   <= acc_d[STAGES-1];
                    y_valid_q <= 1'b1;
                end
            end
        end
    end

    assign y_out    = y_out_q;
    assign y_valid  = y_valid_q;
    assign rate_err = rate_err_q;

endmodule
